// File: rtl/tuner_seq_pkg.sv
// Shared types for the tuner frame sequencer: state encoding and stage-index width helper.
package tuner_seq_pkg;

    typedef enum logic [2:0] {
        IDLE,
        CLEAR,
        RUN,
        GAP,
        FRAME_END,
        ERROR
    } seq_state_t;

    // Wide enough to hold every stage index plus the "no stage" value NUM_STAGES.
    function automatic int stg_w(input int n);
        return $clog2(n + 1);
    endfunction

endpackage

// File: rtl/clk_div_en.sv
// Free-running divider producing the 50% duty microphone clock from clk_100.
module clk_div_en #(
    parameter int DIV = 52
) (
    input  logic clk_100,
    input  logic rst_n,
    output logic mic_clk
);

    localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;

    logic [CW-1:0] div_cnt;

    always_ff @(posedge clk_100) begin
        if (!rst_n) begin
            div_cnt <= '0;
            mic_clk <= 1'b0;
        end else if (div_cnt == CW'(DIV - 1)) begin
            div_cnt <= '0;
            mic_clk <= ~mic_clk;
        end else begin
            div_cnt <= div_cnt + CW'(1);
        end
    end

endmodule

// File: rtl/tuner_seq_ctrl.sv
// Frame sequencer: runs the stages in order with go/done handshakes and owns the shared memory port.
// Optional per-stage watchdog and ERROR state are built when TUNER_SEQ_WDOG_EN is defined.
module tuner_seq_ctrl
    import tuner_seq_pkg::*;
#(
    parameter int NUM_STAGES = 3,
    parameter int ADDR_W     = 11,
    parameter int DATA_W     = 10,
    parameter int FRAME_W    = 8,
    parameter int MIC_DIV    = 52
`ifdef TUNER_SEQ_WDOG_EN
    ,
    parameter int TIMEOUT_CYC = 2**20
`endif
) (
    input  logic                           clk_100,
    input  logic                           rst_n,
    input  logic                           start,
    input  logic                           continuous,
    input  logic                           stop,
    input  logic [NUM_STAGES-1:0]          stg_done,
    input  logic [NUM_STAGES*ADDR_W-1:0]   stg_addr,
    input  logic [NUM_STAGES-1:0]          stg_we,
    input  logic [NUM_STAGES*DATA_W-1:0]   stg_wdata,
    output logic [NUM_STAGES-1:0]          stg_go,
    output logic [ADDR_W-1:0]              mem_addr,
    output logic                           mem_we,
    output logic [DATA_W-1:0]              mem_wdata,
    output logic                           mem_clr_n,
    output logic                           busy,
    output logic [stg_w(NUM_STAGES)-1:0]   cur_stage,
    output logic [FRAME_W-1:0]             frame_cnt,
    output logic                           frame_done,
    output logic                           err_timeout,
    output logic                           mic_clk
);

    localparam int STG_W = stg_w(NUM_STAGES);
    localparam logic [STG_W-1:0] LAST_STG = STG_W'(NUM_STAGES - 1);
    localparam logic [STG_W-1:0] NO_STG   = STG_W'(NUM_STAGES);

    seq_state_t            state, state_nxt;
    logic [STG_W-1:0]      stage_idx, stage_nxt;
    logic [NUM_STAGES-1:0] stage_sel;
    logic                  done_act;
    logic                  stop_pending;
    logic                  cont_lat;
    logic                  wdog_hit;

    assign stage_sel = NUM_STAGES'(1) << stage_idx;
    assign done_act  = |(stg_done & stage_sel);

    always_ff @(posedge clk_100) begin
        if (!rst_n) begin
            state     <= IDLE;
            stage_idx <= '0;
        end else begin
            state     <= state_nxt;
            stage_idx <= stage_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        stage_nxt = stage_idx;
        case (state)
            IDLE:      if (start) state_nxt = CLEAR;
            CLEAR: begin
                state_nxt = RUN;
                stage_nxt = '0;
            end
            RUN: begin
                if (wdog_hit)      state_nxt = ERROR;
                else if (done_act) state_nxt = GAP;
            end
            GAP: begin
                if (wdog_hit) begin
                    state_nxt = ERROR;
                end else if (!done_act) begin
                    if (stage_idx == LAST_STG) begin
                        state_nxt = FRAME_END;
                    end else begin
                        state_nxt = RUN;
                        stage_nxt = stage_idx + STG_W'(1);
                    end
                end
            end
            FRAME_END: state_nxt = (cont_lat && !stop_pending) ? CLEAR : IDLE;
            ERROR:     if (start) state_nxt = CLEAR;
            default:   state_nxt = IDLE;
        endcase
    end

    // The memory port follows the active stage through RUN and GAP, but writes only in RUN.
    always_comb begin
        stg_go    = '0;
        mem_addr  = '0;
        mem_we    = 1'b0;
        mem_wdata = '0;
        cur_stage = NO_STG;
        if (state == RUN || state == GAP) begin
            cur_stage = stage_idx;
            for (int k = 0; k < NUM_STAGES; k++) begin
                if (stage_idx == STG_W'(k)) begin
                    mem_addr  = stg_addr[k*ADDR_W +: ADDR_W];
                    mem_wdata = stg_wdata[k*DATA_W +: DATA_W];
                    mem_we    = (state == RUN) && stg_we[k];
                end
            end
            if (state == RUN) stg_go = stage_sel;
        end
    end

    assign mem_clr_n  = (state != CLEAR);
    assign busy       = (state != IDLE);
    assign frame_done = (state == FRAME_END);

    always_ff @(posedge clk_100) begin
        if (!rst_n) begin
            stop_pending <= 1'b0;
            cont_lat     <= 1'b0;
            frame_cnt    <= '0;
        end else begin
            if (state_nxt == CLEAR && (state == IDLE || state == ERROR)) begin
                stop_pending <= (state == IDLE) ? stop : 1'b0;
            end else if (stop && state != IDLE && state != ERROR) begin
                stop_pending <= 1'b1;
            end
            if (state_nxt == CLEAR) cont_lat <= continuous;
            if (state == FRAME_END) frame_cnt <= frame_cnt + FRAME_W'(1);
        end
    end

`ifdef TUNER_SEQ_WDOG_EN
    localparam int WD_W = $clog2(TIMEOUT_CYC + 1);

    logic [WD_W-1:0] wdog_cnt;

    assign wdog_hit = (state == RUN || state == GAP) && (wdog_cnt == WD_W'(TIMEOUT_CYC - 1));

    // Each stage gets a fresh budget covering both its RUN and its done-release GAP.
    always_ff @(posedge clk_100) begin
        if (!rst_n) begin
            wdog_cnt    <= '0;
            err_timeout <= 1'b0;
        end else begin
            if (state_nxt == RUN && state != RUN) begin
                wdog_cnt <= '0;
            end else if (state == RUN || state == GAP) begin
                wdog_cnt <= wdog_cnt + WD_W'(1);
            end
            if (state == ERROR && start) begin
                err_timeout <= 1'b0;
            end else if (wdog_hit) begin
                err_timeout <= 1'b1;
            end
        end
    end
`else
    assign wdog_hit    = 1'b0;
    assign err_timeout = 1'b0;
`endif

    clk_div_en #(
        .DIV(MIC_DIV)
    ) u_mic_div (
        .clk_100(clk_100),
        .rst_n  (rst_n),
        .mic_clk(mic_clk)
    );

endmodule

// File: tb/tb_tuner_seq_ctrl.sv
// Directed bench for tuner_seq_ctrl: stage models, event scoreboard, mux/handshake/divider checks.
module tb_tuner_seq_ctrl;

    localparam int N        = 3;
    localparam int ADDR_W   = 11;
    localparam int DATA_W   = 10;
    localparam int FRAME_W  = 8;
    localparam int MIC_DIV  = 52;
    localparam int TIMEOUT  = 100;
    localparam int DONE_DLY = 10;
    localparam int EV_CLR   = 0;
    localparam int EV_GO    = 10;
    localparam int EV_FD    = 20;
    localparam int EV_ERR   = 30;

    logic                 clk_100 = 1'b0;
    logic                 rst_n;
    logic                 start;
    logic                 continuous;
    logic                 stop;
    logic [N-1:0]         stg_done;
    logic [N*ADDR_W-1:0]  stg_addr;
    logic [N-1:0]         stg_we;
    logic [N*DATA_W-1:0]  stg_wdata;
    logic [N-1:0]         stg_go;
    logic [ADDR_W-1:0]    mem_addr;
    logic                 mem_we;
    logic [DATA_W-1:0]    mem_wdata;
    logic                 mem_clr_n;
    logic                 busy;
    logic [1:0]           cur_stage;
    logic [FRAME_W-1:0]   frame_cnt;
    logic                 frame_done;
    logic                 err_timeout;
    logic                 mic_clk;

    int exp_q[$];
    int checks = 0;
    int passed = 0;
    int fails  = 0;
    int cyc    = 0;
    int exp_frames = 0;
    int fd_count = 0;
    int go1_rise_cyc = 0;
    int done0_fall_cyc = 0;
    int err_cyc = 0;
    int mic_rises = 0;
    int mic_last_rise = 0;
    int mic_prev_rise = 0;
    int mic_last_fall = 0;
    int hold_extra[N];
    bit never_done[N];

    always #5 clk_100 = ~clk_100;

    always @(posedge clk_100) cyc <= cyc + 1;

    tuner_seq_ctrl #(
        .NUM_STAGES(N),
        .ADDR_W    (ADDR_W),
        .DATA_W    (DATA_W),
        .FRAME_W   (FRAME_W),
        .MIC_DIV   (MIC_DIV)
`ifdef TUNER_SEQ_WDOG_EN
        ,
        .TIMEOUT_CYC(TIMEOUT)
`endif
    ) dut (
        .clk_100    (clk_100),
        .rst_n      (rst_n),
        .start      (start),
        .continuous (continuous),
        .stop       (stop),
        .stg_done   (stg_done),
        .stg_addr   (stg_addr),
        .stg_we     (stg_we),
        .stg_wdata  (stg_wdata),
        .stg_go     (stg_go),
        .mem_addr   (mem_addr),
        .mem_we     (mem_we),
        .mem_wdata  (mem_wdata),
        .mem_clr_n  (mem_clr_n),
        .busy       (busy),
        .cur_stage  (cur_stage),
        .frame_cnt  (frame_cnt),
        .frame_done (frame_done),
        .err_timeout(err_timeout),
        .mic_clk    (mic_clk)
    );

    task automatic check_output(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) passed++;
        else begin
            fails++;
            $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    task automatic check_event(input string tag, input int code);
        if (exp_q.size() == 0) check_output({tag, "_unexpected"}, code, 32'hFFFF_FFFF);
        else                   check_output(tag, code, exp_q.pop_front());
    endtask

    task automatic push_frame(input int frames);
        for (int f = 0; f < frames; f++) begin
            exp_q.push_back(EV_CLR);
            for (int k = 0; k < N; k++) exp_q.push_back(EV_GO + k);
            exp_q.push_back(EV_FD);
            exp_frames++;
        end
    endtask

    // Leaves the caller on the negedge after the start edge, i.e. inside CLEAR.
    task automatic apply_stimulus(input bit cont, input bit stp);
        @(negedge clk_100);
        start      = 1'b1;
        continuous = cont;
        stop       = stp;
        @(negedge clk_100);
        start = 1'b0;
        stop  = 1'b0;
    endtask

    task automatic wait_go(input int k, input int budget);
        for (int i = 0; i < budget && !stg_go[k]; i++) @(negedge clk_100);
        check_output($sformatf("wait_go%0d", k), 32'(stg_go[k]), 1);
    endtask

    task automatic wait_idle(input int budget);
        for (int i = 0; i < budget && busy; i++) @(negedge clk_100);
        check_output("wait_idle", 32'(busy), 0);
    endtask

    // Stage models: done rises DONE_DLY cycles into go, is held hold_extra cycles after go drops.
    initial begin
        int mcnt[N];
        int hcnt[N];
        stg_done = '0;
        for (int k = 0; k < N; k++) begin
            mcnt[k] = 0;
            hcnt[k] = 0;
        end
        forever begin
            @(negedge clk_100);
            for (int k = 0; k < N; k++) begin
                if (!rst_n) begin
                    stg_done[k] = 1'b0;
                    mcnt[k] = 0;
                    hcnt[k] = 0;
                end else if (stg_go[k]) begin
                    hcnt[k] = 0;
                    if (!stg_done[k] && !never_done[k]) begin
                        mcnt[k]++;
                        if (mcnt[k] >= DONE_DLY) stg_done[k] = 1'b1;
                    end
                end else begin
                    mcnt[k] = 0;
                    if (stg_done[k]) begin
                        if (hcnt[k] >= hold_extra[k]) begin
                            stg_done[k] = 1'b0;
                            if (k == 0) done0_fall_cyc = cyc;
                        end else begin
                            hcnt[k]++;
                        end
                    end
                end
            end
        end
    end

    // Event monitor: every observed clear/go/frame_done/error event is matched against the queue.
    initial begin
        logic [N-1:0] go_prev;
        logic err_prev;
        logic mic_prev;
        go_prev  = '0;
        err_prev = 1'b0;
        mic_prev = 1'b0;
        forever begin
            @(negedge clk_100);
            if (rst_n) begin
                if (!mem_clr_n) check_event("clr_pulse", EV_CLR);
                for (int k = 0; k < N; k++) begin
                    if (stg_go[k] && !go_prev[k]) begin
                        if (k == 1) go1_rise_cyc = cyc;
                        check_event("go_rise", EV_GO + k);
                    end
                end
                if (frame_done) begin
                    fd_count++;
                    check_event("frame_done", EV_FD);
                end
                if (err_timeout && !err_prev) begin
                    err_cyc = cyc;
                    check_event("err_rise", EV_ERR);
                end
                if (mic_clk && !mic_prev) begin
                    mic_prev_rise = mic_last_rise;
                    mic_last_rise = cyc;
                    mic_rises++;
                end
                if (!mic_clk && mic_prev) mic_last_fall = cyc;
            end
            go_prev  = stg_go;
            err_prev = err_timeout;
            mic_prev = mic_clk;
        end
    end

    initial begin
        int base;
        int n0;
        rst_n      = 1'b0;
        start      = 1'b0;
        continuous = 1'b0;
        stop       = 1'b0;
        stg_addr   = {11'h7FF, 11'h155, 11'h011};
        stg_we     = 3'b011;
        stg_wdata  = {10'h3FF, 10'h2AA, 10'h0AA};
        for (int k = 0; k < N; k++) begin
            hold_extra[k] = 0;
            never_done[k] = 1'b0;
        end

        repeat (3) @(negedge clk_100);
        check_output("rst_go", 32'(stg_go), 0);
        check_output("rst_busy", 32'(busy), 0);
        check_output("rst_cur_stage", 32'(cur_stage), N);
        check_output("rst_frame_cnt", 32'(frame_cnt), 0);
        check_output("rst_frame_done", 32'(frame_done), 0);
        check_output("rst_clr_n", 32'(mem_clr_n), 1);
        check_output("rst_mem_we", 32'(mem_we), 0);
        check_output("rst_mem_addr", 32'(mem_addr), 0);
        check_output("rst_mem_wdata", 32'(mem_wdata), 0);
        check_output("rst_err", 32'(err_timeout), 0);
        check_output("rst_mic", 32'(mic_clk), 0);
        @(negedge clk_100);
        rst_n = 1'b1;

        $display("[TB] one-shot frame with mux checks");
        push_frame(1);
        apply_stimulus(1'b0, 1'b0);
        check_output("clear_busy", 32'(busy), 1);
        check_output("clear_go", 32'(stg_go), 0);
        @(negedge clk_100);
        check_output("go0_at_t2", 32'(stg_go), 32'b001);
        check_output("run0_addr", 32'(mem_addr), 32'h011);
        check_output("run0_we", 32'(mem_we), 1);
        check_output("run0_wdata", 32'(mem_wdata), 32'h0AA);
        wait_go(1, 100);
        check_output("run1_addr", 32'(mem_addr), 32'h155);
        check_output("run1_we", 32'(mem_we), 1);
        check_output("run1_wdata", 32'(mem_wdata), 32'h2AA);
        check_output("run1_cur_stage", 32'(cur_stage), 1);
        for (int i = 0; i < 50 && stg_go[1]; i++) @(negedge clk_100);
        check_output("gap1_go", 32'(stg_go), 0);
        check_output("gap1_cur_stage", 32'(cur_stage), 1);
        check_output("gap1_addr", 32'(mem_addr), 32'h155);
        check_output("gap1_we", 32'(mem_we), 0);
        check_output("gap1_wdata", 32'(mem_wdata), 32'h2AA);
        wait_idle(300);
        check_output("oneshot_fd_count", 32'(fd_count), 1);
        check_output("oneshot_frame_cnt", 32'(frame_cnt), 32'(exp_frames % 256));
        check_output("idle_cur_stage", 32'(cur_stage), N);

        $display("[TB] handshake: stage 0 holds done 5 cycles");
        hold_extra[0] = 5;
        push_frame(1);
        apply_stimulus(1'b0, 1'b0);
        wait_go(1, 200);
        @(negedge clk_100);
        check_output("go1_after_done0_fall", 32'(go1_rise_cyc - done0_fall_cyc), 1);
        wait_idle(300);
        hold_extra[0] = 0;
        check_output("hs_frame_cnt", 32'(frame_cnt), 32'(exp_frames % 256));

        $display("[TB] continuous mode, stop mid third frame");
        base = fd_count;
        push_frame(3);
        apply_stimulus(1'b1, 1'b0);
        @(negedge clk_100);
        start = 1'b1;
        @(negedge clk_100);
        start = 1'b0;
        for (int i = 0; i < 400 && fd_count < base + 2; i++) @(negedge clk_100);
        check_output("cont_two_frames", 32'(fd_count - base), 2);
        wait_go(1, 200);
        stop = 1'b1;
        @(negedge clk_100);
        stop = 1'b0;
        wait_idle(400);
        repeat (3) @(negedge clk_100);
        check_output("cont_fd_count", 32'(fd_count - base), 3);
        check_output("cont_frame_cnt", 32'(frame_cnt), 32'(exp_frames % 256));

        $display("[TB] start and stop together run one frame");
        base = fd_count;
        push_frame(1);
        apply_stimulus(1'b1, 1'b1);
        wait_idle(300);
        repeat (3) @(negedge clk_100);
        check_output("startstop_fd_count", 32'(fd_count - base), 1);
        check_output("startstop_frame_cnt", 32'(frame_cnt), 32'(exp_frames % 256));

        $display("[TB] mic clock divider");
        n0 = mic_rises;
        for (int i = 0; i < 400 && mic_rises < n0 + 2; i++) @(negedge clk_100);
        @(negedge clk_100);
        check_output("mic_period", 32'(mic_last_rise - mic_prev_rise), 2 * MIC_DIV);
        for (int i = 0; i < 200 && mic_clk; i++) @(negedge clk_100);
        @(negedge clk_100);
        check_output("mic_high_time", 32'(mic_last_fall - mic_last_rise), MIC_DIV);

`ifdef TUNER_SEQ_WDOG_EN
        $display("[TB] watchdog: stage 1 never completes");
        never_done[1] = 1'b1;
        exp_q.push_back(EV_CLR);
        exp_q.push_back(EV_GO + 0);
        exp_q.push_back(EV_GO + 1);
        exp_q.push_back(EV_ERR);
        apply_stimulus(1'b0, 1'b0);
        for (int i = 0; i < 400 && !err_timeout; i++) @(negedge clk_100);
        @(negedge clk_100);
        check_output("wdog_flag", 32'(err_timeout), 1);
        check_output("wdog_latency", 32'(err_cyc - go1_rise_cyc), TIMEOUT);
        check_output("wdog_busy", 32'(busy), 1);
        check_output("wdog_go", 32'(stg_go), 0);
        check_output("wdog_cur_stage", 32'(cur_stage), N);
        never_done[1] = 1'b0;
        push_frame(1);
        apply_stimulus(1'b0, 1'b0);
        check_output("wdog_flag_cleared", 32'(err_timeout), 0);
        @(negedge clk_100);
        check_output("wdog_restart_go0", 32'(stg_go), 32'b001);
        wait_idle(300);
        check_output("wdog_frame_cnt", 32'(frame_cnt), 32'(exp_frames % 256));
`endif

        $display("[TB] reset in the middle of stage 2");
        exp_q.push_back(EV_CLR);
        for (int k = 0; k < N; k++) exp_q.push_back(EV_GO + k);
        apply_stimulus(1'b0, 1'b0);
        wait_go(2, 200);
        rst_n = 1'b0;
        @(negedge clk_100);
        exp_frames = 0;
        check_output("midrst_go", 32'(stg_go), 0);
        check_output("midrst_busy", 32'(busy), 0);
        check_output("midrst_cur_stage", 32'(cur_stage), N);
        check_output("midrst_frame_cnt", 32'(frame_cnt), 0);
        check_output("midrst_clr_n", 32'(mem_clr_n), 1);
        check_output("midrst_mem_we", 32'(mem_we), 0);
        check_output("midrst_mem_addr", 32'(mem_addr), 0);
        check_output("midrst_mic", 32'(mic_clk), 0);
        check_output("midrst_err", 32'(err_timeout), 0);
        @(negedge clk_100);
        rst_n = 1'b1;
        repeat (3) @(negedge clk_100);
        check_output("queue_drained", 32'(exp_q.size()), 0);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
